// File: rtl/mshr_fill_engine.sv
// MSHR fill engine: drains MSHR head entries through an RW lookup into a memory
// request channel and turns memory responses into fill/delete pulses.
module mshr_fill_engine #(
  parameter int addr_tag_bits   = 20,
  parameter int data_bits       = 90,
  parameter int max_outstanding = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     mshr_read_valid,
  input  logic [addr_tag_bits-1:0] mshr_read_addr_tag,
  input  logic [data_bits-1:0]     mshr_read_addr_data,
  output logic                     read_next,
  output logic                     isRW_request,
  output logic [addr_tag_bits-1:0] isRW_tag,
  input  logic                     isRW_valid,
  input  logic                     isRW_RW,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [addr_tag_bits-1:0] mem_req_tag,
  output logic [data_bits-1:0]     mem_req_data,
  output logic                     mem_req_we,
  input  logic                     mem_resp_valid,
  input  logic [addr_tag_bits-1:0] mem_resp_tag,
  input  logic [data_bits-1:0]     mem_resp_data,
  output logic                     fill_valid,
  output logic [addr_tag_bits-1:0] fill_tag,
  output logic [data_bits-1:0]     fill_data,
  output logic                     del,
  output logic [addr_tag_bits-1:0] del_addr_tag,
  output logic [3:0]               outstanding,
  output logic                     resp_err
);

  typedef enum logic [1:0] {IDLE, LOOKUP, ISSUE} state_e;

  localparam logic [3:0] MaxOut = 4'(max_outstanding);

  state_e                   state_q, state_d;
  logic [addr_tag_bits-1:0] tag_q, tag_d;
  logic [data_bits-1:0]     data_q, data_d;
  logic                     we_q, we_d;
  logic [3:0]               outstanding_q, outstanding_d;
  logic                     resp_err_q, resp_err_d;
  logic                     fill_valid_q, fill_valid_d;
  logic [addr_tag_bits-1:0] fill_tag_q, fill_tag_d;
  logic [data_bits-1:0]     fill_data_q, fill_data_d;

  logic capture;
  logic handshake;
  logic resp_ok;

  // read_next is combinational from IDLE, so reset is folded in to keep it low
  // while reset is asserted regardless of the MSHR inputs.
  assign capture   = reset && (state_q == IDLE) && enable && mshr_read_valid &&
                     (outstanding_q < MaxOut);
  assign handshake = (state_q == ISSUE) && mem_req_ready;
  assign resp_ok   = mem_resp_valid && (outstanding_q != 4'd0);

  always_comb begin
    // NOTE: every next-state value gets its hold default first so no path
    // through the case leaves a variable unassigned and infers a latch.
    state_d       = state_q;
    tag_d         = tag_q;
    data_d        = data_q;
    we_d          = we_q;
    outstanding_d = outstanding_q;
    resp_err_d    = resp_err_q;
    fill_valid_d  = resp_ok;
    fill_tag_d    = fill_tag_q;
    fill_data_d   = fill_data_q;

    case (state_q)
      IDLE: begin
        if (capture) begin
          tag_d   = mshr_read_addr_tag;
          data_d  = mshr_read_addr_data;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        // A lookup miss means the entry was already retired; drop silently.
        if (enable) begin
          if (isRW_valid) begin
            we_d    = isRW_RW;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      ISSUE: begin
        if (mem_req_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    case ({handshake, resp_ok})
      2'b10:   outstanding_d = outstanding_q + 4'd1;
      2'b01:   outstanding_d = outstanding_q - 4'd1;
      default: outstanding_d = outstanding_q;
    endcase

    if (resp_ok) begin
      fill_tag_d  = mem_resp_tag;
      fill_data_d = mem_resp_data;
    end
    if (mem_resp_valid && (outstanding_q == 4'd0)) resp_err_d = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; the wide tag/data registers are reset too because
  // they drive outputs that must read zero during reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      tag_q         <= '0;
      data_q        <= '0;
      we_q          <= 1'b0;
      outstanding_q <= 4'd0;
      resp_err_q    <= 1'b0;
      fill_valid_q  <= 1'b0;
      fill_tag_q    <= '0;
      fill_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      tag_q         <= tag_d;
      data_q        <= data_d;
      we_q          <= we_d;
      outstanding_q <= outstanding_d;
      resp_err_q    <= resp_err_d;
      fill_valid_q  <= fill_valid_d;
      fill_tag_q    <= fill_tag_d;
      fill_data_q   <= fill_data_d;
    end
  end

  assign read_next     = capture;
  assign isRW_request  = (state_q == LOOKUP) && enable;
  assign isRW_tag      = tag_q;
  assign mem_req_valid = (state_q == ISSUE);
  assign mem_req_tag   = tag_q;
  assign mem_req_data  = data_q;
  assign mem_req_we    = we_q;
  assign fill_valid    = fill_valid_q;
  assign fill_tag      = fill_tag_q;
  assign fill_data     = fill_data_q;
  assign del           = fill_valid_q;
  assign del_addr_tag  = fill_tag_q;
  assign outstanding   = outstanding_q;
  assign resp_err      = resp_err_q;

endmodule

// File: doc/mshr_fill_engine.md
MSHR_FILL_ENGINE -- requirements
Module: mshr_fill_engine

Interface
REQ-001 SHALL have parameter addr_tag_bits, default 20, line tag width matching the MSHR entry tag.
REQ-002 SHALL have parameter data_bits, default 90, MSHR entry payload width.
REQ-003 SHALL have parameter max_outstanding, default 4, the limit on memory requests in flight (range 1..15).
REQ-004 SHALL have port clk  input  1  the single clock; all state on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  input  1  gates new request capture.
REQ-007 SHALL have port mshr_read_valid  input  1  the MSHR head entry is valid.
REQ-008 SHALL have port mshr_read_addr_tag  input  addr_tag_bits  the MSHR head tag.
REQ-009 SHALL have port mshr_read_addr_data  input  data_bits  the MSHR head payload.
REQ-010 SHALL have port read_next  output  1  a one-cycle pulse that advances the MSHR read pointer.
REQ-011 SHALL have port isRW_request  output  1  the MSHR RW lookup strobe.
REQ-012 SHALL have port isRW_tag  output  addr_tag_bits  the lookup tag.
REQ-013 SHALL have ports isRW_valid and isRW_RW  input  1 each  lookup hit and RW flag (1 = write).
REQ-014 SHALL have ports mem_req_valid  output  1 and mem_req_ready  input  1  a valid/ready pair.
REQ-015 SHALL have ports mem_req_tag  output  addr_tag_bits, mem_req_data  output  data_bits and mem_req_we  output  1.
REQ-016 SHALL have ports mem_resp_valid  input  1, mem_resp_tag  input  addr_tag_bits and mem_resp_data  input  data_bits; there is no backpressure on responses.
REQ-017 SHALL have ports fill_valid  output  1, fill_tag  output  addr_tag_bits and fill_data  output  data_bits.
REQ-018 SHALL have ports del  output  1 and del_addr_tag  output  addr_tag_bits  which retire the entry in the MSHR.
REQ-019 SHALL have ports outstanding  output  4  the in-flight count, and resp_err  output  1  a sticky error flag.

Function
REQ-020 SHALL implement a three-state FSM with states IDLE, LOOKUP and ISSUE.
REQ-021 SHALL, in IDLE with enable=1, mshr_read_valid=1 and outstanding<max_outstanding, capture the tag and data, pulse read_next for one cycle, drive isRW_request=1 with isRW_tag set to the captured tag, and go to LOOKUP.
REQ-022 SHALL, in LOOKUP, sample isRW_valid and isRW_RW; if isRW_valid=1, latch mem_req_we=isRW_RW and go to ISSUE; if isRW_valid=0, drop the request (the entry has already been deleted) and return to IDLE with no memory request.
REQ-023 SHALL, in ISSUE, hold mem_req_valid=1 with tag, data and we stable until mem_req_ready=1; on the handshake cycle it SHALL increment outstanding and go to IDLE.
REQ-024 SHALL give a minimum issue cadence of one request per 3 cycles: IDLE->LOOKUP->ISSUE with ready=1.
REQ-025 SHALL not deassert mem_req_valid once it is asserted, and SHALL ignore enable while in ISSUE.
REQ-026 SHALL, while enable=0, hold the FSM in IDLE or LOOKUP and perform no new capture; response processing continues.
REQ-027 SHALL, on mem_resp_valid=1 with outstanding>0, assert fill_valid and del in the next cycle for exactly one cycle, with fill_tag=del_addr_tag=mem_resp_tag and fill_data=mem_resp_data, and decrement outstanding.
REQ-028 SHALL, on mem_resp_valid=1 with outstanding=0, produce no fill and no del, and set resp_err until reset.
REQ-029 SHALL, when a request handshake and a response occur in the same cycle, leave outstanding unchanged.
REQ-030 SHALL accept back-to-back responses every cycle, producing one fill/del pulse per response.
REQ-031 SHALL hold capture in IDLE at outstanding=max_outstanding until a response decrements the count.
REQ-032 SHALL drive read_next, isRW_request, fill_valid and del as single-cycle pulses and never hold them high across consecutive captures.

Reset
REQ-033 SHALL, while reset=0, asynchronously force the FSM to IDLE; outstanding, resp_err, read_next, isRW_request, mem_req_valid, mem_req_we, fill_valid and del to 0; and all tag and data outputs to 0.
REQ-034 SHALL, when reset is asserted mid-ISSUE, abandon the request without a handshake; responses arriving after reset is released with outstanding=0 set resp_err.

Verification
REQ-035 SHALL be tested as follows: MSHR head tag=1, data=100, RW=0, ready=1 -> read_next pulse at cycle 0, mem_req at cycle 2 with tag=1, data=100, we=0, and outstanding=1.
REQ-036 SHALL be tested as follows: head tag=3 with isRW_RW=1, ready held 0 for 3 cycles -> mem_req_valid is stable for 4 cycles with we=1 and outstanding increments only on the ready cycle.
REQ-037 SHALL be tested as follows: 5 heads with ready=1 and no responses -> exactly 4 issued, the 5th held in IDLE, and read_next is not pulsed for it until a response for tag=2 -> fill/del tag=2, after which the 5th issues.
REQ-038 SHALL be tested as follows: isRW_valid=0 during LOOKUP for tag=4 -> no mem_req, FSM returns to IDLE, and outstanding is unchanged.
REQ-039 SHALL be tested as follows: handshake and mem_resp_valid (tag=1) in the same cycle at outstanding=2 -> outstanding stays 2 and del pulses with tag=1 the next cycle.
REQ-040 SHALL be tested as follows: a response at outstanding=0 -> resp_err=1, no del; then reset=0 -> resp_err=0 and all outputs 0.
